// File: rtl/aes_mode_pkg.sv
// rtl/aes_mode_pkg.sv - mode and FSM state encodings shared by the AES mode controller
package aes_mode_pkg;
   localparam int BLK_W = 128;

   typedef enum logic [1:0] {
      MODE_ECB  = 2'b00,
      MODE_CBC  = 2'b01,
      MODE_CTR  = 2'b10,
      MODE_RSVD = 2'b11
   } mode_e;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WAIT_IN = 3'd1,
      ST_LOAD    = 3'd2,
      ST_CORE    = 3'd3,
      ST_OUT     = 3'd4
   } state_e;
endpackage

// File: rtl/aes_mode_ctrl_if.sv
// rtl/aes_mode_ctrl_if.sv - message, block-stream and core-side signals of the AES mode controller
interface aes_mode_ctrl_if #(parameter int CNT_W = 16);
   import aes_mode_pkg::*;

   logic [1:0]       Mode;
   logic             Decrypt;
   logic [BLK_W-1:0] IV;
   logic             Start;
   logic             InValid;
   logic             InReady;
   logic [BLK_W-1:0] InText;
   logic             InLast;
   logic             OutValid;
   logic             OutReady;
   logic [BLK_W-1:0] OutText;
   logic             OutLast;
   logic             CoreRst;
   logic             CoreEn;
   logic             CoreDec;
   logic [BLK_W-1:0] CoreIn;
   logic             CoreRy;
   logic [BLK_W-1:0] CoreOut;
   logic             Busy;
   logic             Error;
   logic [CNT_W-1:0] BlockCnt;

   modport master (
      output Mode, Decrypt, IV, Start, InValid, InText, InLast, OutReady, CoreRy, CoreOut,
      input  InReady, OutValid, OutText, OutLast, CoreRst, CoreEn, CoreDec, CoreIn,
             Busy, Error, BlockCnt
   );

   modport slave (
      input  Mode, Decrypt, IV, Start, InValid, InText, InLast, OutReady, CoreRy, CoreOut,
      output InReady, OutValid, OutText, OutLast, CoreRst, CoreEn, CoreDec, CoreIn,
             Busy, Error, BlockCnt
   );
endinterface

// File: rtl/aes_mode_datapath.sv
// rtl/aes_mode_datapath.sv - per-mode core input selection, pre/post XOR and next chain value
module aes_mode_datapath
   import aes_mode_pkg::*;
#(
   parameter int CTR_W = 32
) (
   input  mode_e                  mode,
   input  logic                   decrypt,
   input  logic [BLK_W-1:0]       in_text,
   input  logic [BLK_W-1:0]       chain,
   input  logic [BLK_W-1:CTR_W]   iv_hi,
   input  logic [CTR_W-1:0]       ctr,
   input  logic [BLK_W-1:0]       core_out,
   output logic [BLK_W-1:0]       core_in,
   output logic                   core_dec,
   output logic [BLK_W-1:0]       result,
   output logic [BLK_W-1:0]       chain_next
);
   always_comb begin
      core_in    = in_text;
      core_dec   = decrypt;
      result     = core_out;
      chain_next = chain;
      case (mode)
         MODE_CBC: begin
            if (decrypt) begin
               result     = core_out ^ chain;
               chain_next = in_text;
            end else begin
               core_in    = in_text ^ chain;
               chain_next = core_out;
            end
         end
         // CTR always runs the core forward; the keystream XOR makes it its own inverse
         MODE_CTR: begin
            core_in  = {iv_hi, ctr};
            core_dec = 1'b0;
            result   = core_out ^ in_text;
         end
         default: ;
      endcase
   end
endmodule

// File: rtl/aes_mode_ctrl.sv
// rtl/aes_mode_ctrl.sv - AES block-mode sequencer (ECB/CBC/CTR) driving an external AES core
module aes_mode_ctrl
   import aes_mode_pkg::*;
#(
   parameter int CTR_W = 32,
   parameter int CNT_W = 16
) (
   input  logic           Clk,
   input  logic           Rst,
   aes_mode_ctrl_if.slave bus
);
   state_e               state_q, state_d;
   mode_e                mode_q, mode_d;
   logic                 dec_q, dec_d;
   logic [BLK_W-1:CTR_W] iv_hi_q, iv_hi_d;
   logic [BLK_W-1:0]     chain_q, chain_d;
   logic [CTR_W-1:0]     ctr_q, ctr_d;
   logic [BLK_W-1:0]     in_text_q, in_text_d;
   logic                 in_last_q, in_last_d;
   logic [BLK_W-1:0]     out_text_q, out_text_d;
   logic                 out_last_q, out_last_d;
   logic                 out_valid_q, out_valid_d;
   logic                 in_ready_q, in_ready_d;
   logic                 core_rst_q, core_rst_d;
   logic                 core_en_q, core_en_d;
   logic                 core_dec_q, core_dec_d;
   logic [BLK_W-1:0]     core_in_q, core_in_d;
   logic                 busy_q, busy_d;
   logic                 error_q, error_d;
   logic [CNT_W-1:0]     block_cnt_q, block_cnt_d;

   logic [BLK_W-1:0]     dp_core_in, dp_result, dp_chain_next;
   logic                 dp_core_dec;

   aes_mode_datapath #(.CTR_W(CTR_W)) u_datapath (
      .mode       (mode_q),
      .decrypt    (dec_q),
      .in_text    (in_text_q),
      .chain      (chain_q),
      .iv_hi      (iv_hi_q),
      .ctr        (ctr_q),
      .core_out   (bus.CoreOut),
      .core_in    (dp_core_in),
      .core_dec   (dp_core_dec),
      .result     (dp_result),
      .chain_next (dp_chain_next)
   );

   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      dec_d       = dec_q;
      iv_hi_d     = iv_hi_q;
      chain_d     = chain_q;
      ctr_d       = ctr_q;
      in_text_d   = in_text_q;
      in_last_d   = in_last_q;
      out_text_d  = out_text_q;
      out_last_d  = out_last_q;
      out_valid_d = out_valid_q;
      in_ready_d  = in_ready_q;
      core_rst_d  = 1'b0;
      core_en_d   = core_en_q;
      core_dec_d  = core_dec_q;
      core_in_d   = core_in_q;
      busy_d      = busy_q;
      error_d     = 1'b0;
      block_cnt_d = block_cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.Start) begin
               if (mode_e'(bus.Mode) == MODE_RSVD) begin
                  error_d = 1'b1;
               end else begin
                  mode_d      = mode_e'(bus.Mode);
                  dec_d       = bus.Decrypt;
                  iv_hi_d     = bus.IV[BLK_W-1:CTR_W];
                  chain_d     = bus.IV;
                  ctr_d       = bus.IV[CTR_W-1:0];
                  block_cnt_d = '0;
                  busy_d      = 1'b1;
                  in_ready_d  = 1'b1;
                  state_d     = ST_WAIT_IN;
               end
            end
         end
         ST_WAIT_IN: begin
            if (bus.InValid) begin
               in_text_d  = bus.InText;
               in_last_d  = bus.InLast;
               in_ready_d = 1'b0;
               core_rst_d = 1'b1;
               state_d    = ST_LOAD;
            end
         end
         // Core operands are frozen here so they stay stable for the whole CORE phase
         ST_LOAD: begin
            core_in_d  = dp_core_in;
            core_dec_d = dp_core_dec;
            core_en_d  = 1'b1;
            state_d    = ST_CORE;
         end
         ST_CORE: begin
            if (bus.CoreRy) begin
               out_text_d  = dp_result;
               out_last_d  = in_last_q;
               chain_d     = dp_chain_next;
               if (mode_q == MODE_CTR) begin
                  ctr_d = ctr_q + CTR_W'(1);
               end
               core_en_d   = 1'b0;
               out_valid_d = 1'b1;
               state_d     = ST_OUT;
            end
         end
         ST_OUT: begin
            if (bus.OutReady) begin
               out_valid_d = 1'b0;
               block_cnt_d = block_cnt_q + CNT_W'(1);
               if (out_last_q) begin
                  busy_d  = 1'b0;
                  state_d = ST_IDLE;
               end else begin
                  in_ready_d = 1'b1;
                  state_d    = ST_WAIT_IN;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q     <= ST_IDLE;
         mode_q      <= MODE_ECB;
         dec_q       <= 1'b0;
         iv_hi_q     <= '0;
         chain_q     <= '0;
         ctr_q       <= '0;
         in_text_q   <= '0;
         in_last_q   <= 1'b0;
         out_text_q  <= '0;
         out_last_q  <= 1'b0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b0;
         core_rst_q  <= 1'b0;
         core_en_q   <= 1'b0;
         core_dec_q  <= 1'b0;
         core_in_q   <= '0;
         busy_q      <= 1'b0;
         error_q     <= 1'b0;
         block_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         dec_q       <= dec_d;
         iv_hi_q     <= iv_hi_d;
         chain_q     <= chain_d;
         ctr_q       <= ctr_d;
         in_text_q   <= in_text_d;
         in_last_q   <= in_last_d;
         out_text_q  <= out_text_d;
         out_last_q  <= out_last_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
         core_rst_q  <= core_rst_d;
         core_en_q   <= core_en_d;
         core_dec_q  <= core_dec_d;
         core_in_q   <= core_in_d;
         busy_q      <= busy_d;
         error_q     <= error_d;
         block_cnt_q <= block_cnt_d;
      end
   end

   assign bus.InReady  = in_ready_q;
   assign bus.OutValid = out_valid_q;
   assign bus.OutText  = out_text_q;
   assign bus.OutLast  = out_last_q;
   assign bus.CoreRst  = core_rst_q;
   assign bus.CoreEn   = core_en_q;
   assign bus.CoreDec  = core_dec_q;
   assign bus.CoreIn   = core_in_q;
   assign bus.Busy     = busy_q;
   assign bus.Error    = error_q;
   assign bus.BlockCnt = block_cnt_q;
endmodule

// File: tb/tb_aes_mode_ctrl.sv
// tb/tb_aes_mode_ctrl.sv - directed scoreboard bench for aes_mode_ctrl with a behavioural AES-128 core
module tb_aes_mode_ctrl;
   import aes_mode_pkg::*;

   localparam int CTR_W = 32;
   localparam int CNT_W = 16;

   localparam logic [127:0] KEY_FIPS = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] KEY_SP   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] IV0      = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] IV_CTR   = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
   localparam logic [127:0] IV_WRAP  = 128'h0123456789abcdef01234567ffffffff;
   localparam logic [127:0] P1       = 128'h6bc1bee22e409f96e93d7e117393172a;
   localparam logic [127:0] P2       = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
   localparam logic [127:0] C1_CBC   = 128'h7649abac8119b246cee98e9b12e9197d;
   localparam logic [127:0] C1_CTR   = 128'h874d6191b620e3261bef6864990db6ce;

   logic Clk = 1'b0;
   logic Rst = 1'b1;
   always #5 Clk = ~Clk;

   aes_mode_ctrl_if #(.CNT_W(CNT_W)) bus ();

   aes_mode_ctrl #(.CTR_W(CTR_W), .CNT_W(CNT_W)) dut (
      .Clk (Clk),
      .Rst (Rst),
      .bus (bus.slave)
   );

   typedef struct { logic [127:0] text; logic last; } exp_t;
   exp_t         exp_q[$];
   logic [127:0] core_log[$];
   int           n_checks = 0;
   int           n_errors = 0;

   logic [7:0]   sbox [256];
   logic [7:0]   isbox [256];
   logic [127:0] rk [11];

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xt(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
      return 8'((x << n) | (x >> (8 - n)));
   endfunction

   task automatic init_tables();
      logic [7:0] a8, inv, s;
      for (int a = 0; a < 256; a++) begin
         a8  = 8'(a);
         inv = 8'h00;
         for (int b = 1; b < 256; b++) if (gm(a8, 8'(b)) == 8'h01) inv = 8'(b);
         s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
         sbox[a8] = s;
         isbox[s] = a8;
      end
   endtask

   task automatic set_key(input logic [127:0] key);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = 32'(key >> (96 - 32 * i));
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
            t[31:24] = t[31:24] ^ rc;
            rc = xt(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   function automatic logic [127:0] aes_enc(input logic [127:0] pt);
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [7:0]   a0, a1, a2, a3;
      logic [127:0] v;
      v = pt ^ rk[0];
      for (int r = 1; r <= 10; r++) begin
         for (int i = 0; i < 16; i++) s[i] = 8'(v >> (120 - 8 * i));
         for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++) t[w+4*c] = sbox[s[w + 4*((c + w) % 4)]];
         if (r < 10) begin
            for (int c = 0; c < 4; c++) begin
               a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
               t[4*c]   = gm(a0, 8'd2) ^ gm(a1, 8'd3) ^ a2 ^ a3;
               t[4*c+1] = a0 ^ gm(a1, 8'd2) ^ gm(a2, 8'd3) ^ a3;
               t[4*c+2] = a0 ^ a1 ^ gm(a2, 8'd2) ^ gm(a3, 8'd3);
               t[4*c+3] = gm(a0, 8'd3) ^ a1 ^ a2 ^ gm(a3, 8'd2);
            end
         end
         v = '0;
         for (int i = 0; i < 16; i++) v = {v[119:0], t[i]};
         v = v ^ rk[r];
      end
      return v;
   endfunction

   function automatic logic [127:0] aes_dec(input logic [127:0] ct);
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [7:0]   a0, a1, a2, a3;
      logic [127:0] v;
      v = ct ^ rk[10];
      for (int r = 9; r >= 0; r--) begin
         for (int i = 0; i < 16; i++) s[i] = 8'(v >> (120 - 8 * i));
         for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++) t[w+4*c] = isbox[s[w + 4*((c - w + 4) % 4)]];
         v = '0;
         for (int i = 0; i < 16; i++) v = {v[119:0], t[i]};
         v = v ^ rk[r];
         if (r > 0) begin
            for (int i = 0; i < 16; i++) s[i] = 8'(v >> (120 - 8 * i));
            for (int c = 0; c < 4; c++) begin
               a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
               t[4*c]   = gm(a0, 8'd14) ^ gm(a1, 8'd11) ^ gm(a2, 8'd13) ^ gm(a3, 8'd9);
               t[4*c+1] = gm(a0, 8'd9)  ^ gm(a1, 8'd14) ^ gm(a2, 8'd11) ^ gm(a3, 8'd13);
               t[4*c+2] = gm(a0, 8'd13) ^ gm(a1, 8'd9)  ^ gm(a2, 8'd14) ^ gm(a3, 8'd11);
               t[4*c+3] = gm(a0, 8'd11) ^ gm(a1, 8'd13) ^ gm(a2, 8'd9)  ^ gm(a3, 8'd14);
            end
            v = '0;
            for (int i = 0; i < 16; i++) v = {v[119:0], t[i]};
         end
      end
      return v;
   endfunction

   // Behavioural core: captures operands when enabled, answers after 1..20 cycles
   logic         core_active = 1'b0;
   int           core_cnt = 0;
   int           core_unstable = 0;
   logic [127:0] core_cap, core_res;
   logic         core_dcap;

   always @(negedge Clk) begin
      if (bus.CoreRst === 1'b1 || bus.CoreEn !== 1'b1) begin
         bus.CoreRy  = 1'b0;
         core_active = 1'b0;
      end else if (!core_active) begin
         core_active = 1'b1;
         core_cnt    = $urandom_range(1, 20);
         core_cap    = bus.CoreIn;
         core_dcap   = bus.CoreDec;
         core_res    = bus.CoreDec ? aes_dec(bus.CoreIn) : aes_enc(bus.CoreIn);
         core_log.push_back(bus.CoreIn);
      end else begin
         if (bus.CoreIn !== core_cap || bus.CoreDec !== core_dcap) core_unstable++;
         if (core_cnt > 1) begin
            core_cnt--;
         end else begin
            bus.CoreRy  = 1'b1;
            bus.CoreOut = core_res;
         end
      end
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic start_msg(input logic [1:0] m, input logic d, input logic [127:0] iv);
      bus.Mode    = m;
      bus.Decrypt = d;
      bus.IV      = iv;
      bus.Start   = 1'b1;
      @(negedge Clk);
      bus.Start   = 1'b0;
   endtask

   task automatic send_block(input logic [127:0] text, input logic last, input logic [127:0] exp_text);
      int n;
      n = 0;
      while (bus.InReady !== 1'b1 && n < 100) begin
         @(negedge Clk);
         n++;
      end
      chk("in_ready before send", 128'(bus.InReady), 128'(1));
      bus.InText  = text;
      bus.InLast  = last;
      bus.InValid = 1'b1;
      exp_q.push_back('{text: exp_text, last: last});
      @(negedge Clk);
      bus.InValid = 1'b0;
   endtask

   task automatic recv_block(input string tag);
      exp_t e;
      int   n;
      bus.OutReady = 1'b1;
      n = 0;
      while (bus.OutValid !== 1'b1 && n < 400) begin
         @(negedge Clk);
         n++;
      end
      chk({tag, " out_valid"}, 128'(bus.OutValid), 128'(1));
      if (bus.OutValid === 1'b1 && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk({tag, " text"}, bus.OutText, e.text);
         chk({tag, " last"}, 128'(bus.OutLast), 128'(e.last));
         chk({tag, " in_ready low"}, 128'(bus.InReady), 128'(0));
      end
      @(negedge Clk);
      bus.OutReady = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " flags"}, 128'({bus.Busy, bus.Error, bus.InReady, bus.OutValid, bus.OutLast,
                                 bus.CoreEn, bus.CoreDec, bus.CoreRst}), 128'(0));
      chk({tag, " block_cnt"}, 128'(bus.BlockCnt), 128'(0));
      chk({tag, " out_text"}, bus.OutText, 128'(0));
      chk({tag, " core_in"}, bus.CoreIn, 128'(0));
   endtask

   initial begin
      logic [127:0] c2, snap;
      logic         stable, no_rdy;
      int           n;

      init_tables();
      bus.Mode = 2'b00; bus.Decrypt = 1'b0; bus.IV = '0; bus.Start = 1'b0;
      bus.InValid = 1'b0; bus.InText = '0; bus.InLast = 1'b0; bus.OutReady = 1'b0;
      Rst = 1'b1;
      repeat (3) @(negedge Clk);
      chk_all_zero("reset");
      Rst = 1'b0;
      @(negedge Clk);

      set_key(KEY_FIPS);
      start_msg(2'b00, 1'b0, '0);
      chk("ecb busy", 128'(bus.Busy), 128'(1));
      send_block(128'h00112233445566778899aabbccddeeff, 1'b1, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
      recv_block("ecb");
      chk("ecb block_cnt", 128'(bus.BlockCnt), 128'(1));
      chk("ecb idle", 128'(bus.Busy), 128'(0));

      set_key(KEY_SP);
      c2 = aes_enc(P2 ^ C1_CBC);
      start_msg(2'b01, 1'b0, IV0);
      send_block(P1, 1'b0, C1_CBC);
      recv_block("cbc enc b1");
      send_block(P2, 1'b1, c2);
      recv_block("cbc enc b2");
      chk("cbc enc block_cnt", 128'(bus.BlockCnt), 128'(2));

      start_msg(2'b01, 1'b1, IV0);
      send_block(C1_CBC, 1'b0, P1);
      recv_block("cbc dec b1");
      send_block(c2, 1'b1, P2);
      recv_block("cbc dec b2");

      core_log.delete();
      start_msg(2'b10, 1'b1, IV_CTR);
      bus.Mode  = 2'b00;
      bus.Start = 1'b1;
      @(negedge Clk);
      bus.Start = 1'b0;
      send_block(P1, 1'b0, C1_CTR);
      recv_block("ctr b1");
      send_block(P2, 1'b1, aes_enc({IV_CTR[127:32], 32'hfcfdff00}) ^ P2);
      recv_block("ctr b2");
      chk("ctr log size", 128'(core_log.size()), 128'(2));
      if (core_log.size() == 2) begin
         chk("ctr core_in b1", core_log[0], IV_CTR);
         chk("ctr core_in b2", core_log[1], {IV_CTR[127:32], 32'hfcfdff00});
      end

      core_log.delete();
      start_msg(2'b10, 1'b0, IV_WRAP);
      send_block(P1, 1'b0, aes_enc(IV_WRAP) ^ P1);
      recv_block("ctr wrap b1");
      send_block(P2, 1'b1, aes_enc({IV_WRAP[127:32], 32'h00000000}) ^ P2);
      recv_block("ctr wrap b2");
      chk("ctr wrap log size", 128'(core_log.size()), 128'(2));
      if (core_log.size() == 2) chk("ctr wrap core_in b2", core_log[1], {IV_WRAP[127:32], 32'h00000000});

      start_msg(2'b00, 1'b0, '0);
      send_block(P1, 1'b0, aes_enc(P1));
      n = 0;
      while (bus.OutValid !== 1'b1 && n < 400) begin
         @(negedge Clk);
         n++;
      end
      chk("stall out_valid", 128'(bus.OutValid), 128'(1));
      snap   = bus.OutText;
      stable = 1'b1;
      no_rdy = 1'b1;
      repeat (50) begin
         @(negedge Clk);
         if (bus.OutText !== snap || bus.OutValid !== 1'b1) stable = 1'b0;
         if (bus.InReady !== 1'b0) no_rdy = 1'b0;
      end
      chk("stall out stable", 128'(stable), 128'(1));
      chk("stall no in_ready", 128'(no_rdy), 128'(1));
      recv_block("stall b1");
      send_block(P2, 1'b1, aes_enc(P2));
      recv_block("stall b2");
      chk("stall block_cnt", 128'(bus.BlockCnt), 128'(2));

      start_msg(2'b00, 1'b0, '0);
      send_block(P1, 1'b0, aes_enc(P1));
      recv_block("rst pre b1");
      send_block(P2, 1'b1, aes_enc(P2));
      n = 0;
      while (bus.CoreEn !== 1'b1 && n < 100) begin
         @(negedge Clk);
         n++;
      end
      chk("mid core enable", 128'(bus.CoreEn), 128'(1));
      Rst = 1'b1;
      @(negedge Clk);
      Rst = 1'b0;
      exp_q.delete();
      chk_all_zero("mid core reset");

      bus.Mode  = 2'b00;
      bus.Start = 1'b1;
      Rst       = 1'b1;
      @(negedge Clk);
      Rst       = 1'b0;
      bus.Start = 1'b0;
      chk("rst beats start busy", 128'(bus.Busy), 128'(0));
      chk("rst beats start in_ready", 128'(bus.InReady), 128'(0));

      start_msg(2'b11, 1'b0, '0);
      chk("rsvd error pulse", 128'(bus.Error), 128'(1));
      chk("rsvd busy", 128'(bus.Busy), 128'(0));
      @(negedge Clk);
      chk("rsvd error clears", 128'(bus.Error), 128'(0));
      chk("rsvd still idle", 128'(bus.Busy), 128'(0));

      chk("core operands stable", 128'(core_unstable), 128'(0));
      chk("scoreboard drained", 128'(exp_q.size()), 128'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end
endmodule
